brdg_actag_table: RTL and testbench

Receive-side counterpart of the bridge's acTag assignment path. Decodes the AFU-to-TLX command stream, captures every assign_actag (opcode 0x50) into a per-acTag table of PASIDs, and answers single-cycle-latency lookups of acTag to PASID. Used by the command checker and the TLX-side models to validate that every later command carries an acTag that has already been assigned.

---
 rtl/brdg_actag_table_pkg.sv | 23 ++
 rtl/brdg_actag_ram.sv | 27 ++
 rtl/brdg_actag_table.sv | 142 ++++++++++++++
 tb/tb_brdg_actag_table.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/brdg_actag_table_pkg.sv
// Shared constants and types for the receive-side acTag table.
// The opcode value matches the one used by the transmit-side surveil block.
package brdg_actag_table_pkg;

    localparam int CTXW   = 4;
    localparam int ACTAGW = 12;
    localparam int PASIDW = 20;

    localparam logic [7:0] AFU_TLX_CMD_OPCODE_ASSIGN_ACTAG = 8'h50;
    localparam logic [7:0] OPC_ASSIGN_ACTAG                = AFU_TLX_CMD_OPCODE_ASSIGN_ACTAG;

    typedef struct packed {
        logic              hit;
        logic [PASIDW-1:0] pasid;
    } lkup_rsp_t;

    // Effective number of usable acTags: the configured length clipped to the table depth.
    function automatic logic [ACTAGW-1:0] eff_limit(input logic [ACTAGW-1:0] len,
                                                    input logic [ACTAGW-1:0] depth);
        return (len < depth) ? len : depth;
    endfunction

endpackage

// File: rtl/brdg_actag_ram.sv
// PASID storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the valid bits in the top qualify them.
module brdg_actag_ram #(
    parameter int IDXW = 4,
    parameter int W    = 20
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IDXW-1:0] waddr,
    input  logic [W-1:0]    wdata,
    input  logic [IDXW-1:0] raddr,
    output logic [W-1:0]    rdata
);

    localparam int DEPTH = 2**IDXW;

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/brdg_actag_table.sv
// acTag -> PASID table fed by assign_actag commands, with one-cycle lookups
// and a write-through bypass for a same-cycle assign/lookup of one acTag.
module brdg_actag_table
    import brdg_actag_table_pkg::*;
#(
    parameter int IDXW = CTXW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       cfg_actag_base,
    input  logic [11:0]       cfg_actag_len,
    input  logic              tbl_clear,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_opcode,
    input  logic [11:0]       cmd_actag,
    input  logic [19:0]       cmd_pasid,
    input  logic              lkup_valid,
    input  logic [11:0]       lkup_actag,
    output logic              lkup_rsp_valid,
    output logic              lkup_rsp_hit,
    output logic [19:0]       lkup_rsp_pasid,
    output logic              assign_pulse,
    output logic              reassign_pulse,
    output logic              err_range,
    output logic [IDXW:0]     valid_cnt
);

    localparam int          DEPTH    = 2**IDXW;
    localparam logic [11:0] DEPTH_12 = 12'(DEPTH);

    logic [11:0]     limit;
    logic [11:0]     cmd_off;
    logic [11:0]     lk_off;
    logic            is_assign;
    logic            cmd_in_range;
    logic            lk_in_range;
    logic            accept;
    logic            bypass;
    logic [IDXW-1:0] cmd_idx;
    logic [IDXW-1:0] lk_idx;

    logic [IDXW-1:0] rd_addr  [2];
    logic [19:0]     rd_pasid [2];

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IDXW:0]    valid_cnt_q, valid_cnt_d;
    logic             assign_q, reassign_q, reassign_d;
    logic             err_range_q;
    logic             rsp_valid_q;
    lkup_rsp_t        rsp_q, rsp_d;

    // 12-bit modular offsets: a base wrap yields a huge offset and fails the range check.
    assign limit        = eff_limit(cfg_actag_len, DEPTH_12);
    assign cmd_off      = cmd_actag - cfg_actag_base;
    assign lk_off       = lkup_actag - cfg_actag_base;
    assign cmd_in_range = (cmd_off < limit);
    assign lk_in_range  = (lk_off < limit);
    assign cmd_idx      = cmd_off[IDXW-1:0];
    assign lk_idx       = lk_off[IDXW-1:0];

    assign is_assign = cmd_valid && (cmd_opcode == OPC_ASSIGN_ACTAG);
    assign accept    = is_assign && cmd_in_range && !tbl_clear;
    // Both offsets are below DEPTH when in range, so equal indices mean equal acTags.
    assign bypass    = accept && lk_in_range && (lk_idx == cmd_idx);

    // Two identical copies give the lookup and the reassign-compare their own read port.
    assign rd_addr[0] = lk_idx;
    assign rd_addr[1] = cmd_idx;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ram
            brdg_actag_ram #(
                .IDXW (IDXW),
                .W    (20)
            ) u_ram (
                .clk   (clk),
                .we    (accept),
                .waddr (cmd_idx),
                .wdata (cmd_pasid),
                .raddr (rd_addr[gi]),
                .rdata (rd_pasid[gi])
            );
        end
    endgenerate

    always_comb begin
        valid_d     = valid_q;
        valid_cnt_d = valid_cnt_q;
        if (tbl_clear) begin
            valid_d     = '0;
            valid_cnt_d = '0;
        end else if (accept) begin
            valid_d[cmd_idx] = 1'b1;
            if (!valid_q[cmd_idx]) begin
                valid_cnt_d = valid_cnt_q + (IDXW+1)'(1);
            end
        end
    end

    always_comb begin
        reassign_d = accept && valid_q[cmd_idx] && (rd_pasid[1] != cmd_pasid);
        rsp_d.hit  = lkup_valid && !tbl_clear && lk_in_range && (bypass || valid_q[lk_idx]);
        if (!rsp_d.hit) begin
            rsp_d.pasid = '0;
        end else if (bypass) begin
            rsp_d.pasid = cmd_pasid;
        end else begin
            rsp_d.pasid = rd_pasid[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            valid_cnt_q <= '0;
            assign_q    <= 1'b0;
            reassign_q  <= 1'b0;
            err_range_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            valid_cnt_q <= valid_cnt_d;
            assign_q    <= accept;
            reassign_q  <= reassign_d;
            if (is_assign && !cmd_in_range) begin
                err_range_q <= 1'b1;
            end
            rsp_valid_q <= lkup_valid;
            rsp_q       <= rsp_d;
        end
    end

    assign lkup_rsp_valid = rsp_valid_q;
    assign lkup_rsp_hit   = rsp_q.hit;
    assign lkup_rsp_pasid = rsp_q.pasid;
    assign assign_pulse   = assign_q;
    assign reassign_pulse = reassign_q;
    assign err_range      = err_range_q;
    assign valid_cnt      = valid_cnt_q;

endmodule

// File: tb/tb_brdg_actag_table.sv
// Directed bench for brdg_actag_table: assignment, range errors, reassign,
// bypass, clear priority and reset during a lookup.
module tb_brdg_actag_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] cfg_actag_base = 12'h100;
    logic [11:0] cfg_actag_len = 12'd16;
    logic        tbl_clear = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_opcode = 8'h00;
    logic [11:0] cmd_actag = 12'h000;
    logic [19:0] cmd_pasid = 20'h0;
    logic        lkup_valid = 1'b0;
    logic [11:0] lkup_actag = 12'h000;
    logic        lkup_rsp_valid;
    logic        lkup_rsp_hit;
    logic [19:0] lkup_rsp_pasid;
    logic        assign_pulse;
    logic        reassign_pulse;
    logic        err_range;
    logic [4:0]  valid_cnt;

    int total = 0;
    int bad   = 0;

    brdg_actag_table dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_actag_base (cfg_actag_base),
        .cfg_actag_len  (cfg_actag_len),
        .tbl_clear      (tbl_clear),
        .cmd_valid      (cmd_valid),
        .cmd_opcode     (cmd_opcode),
        .cmd_actag      (cmd_actag),
        .cmd_pasid      (cmd_pasid),
        .lkup_valid     (lkup_valid),
        .lkup_actag     (lkup_actag),
        .lkup_rsp_valid (lkup_rsp_valid),
        .lkup_rsp_hit   (lkup_rsp_hit),
        .lkup_rsp_pasid (lkup_rsp_pasid),
        .assign_pulse   (assign_pulse),
        .reassign_pulse (reassign_pulse),
        .err_range      (err_range),
        .valid_cnt      (valid_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [7:0] opc, input logic [11:0] tag, input logic [19:0] pasid);
        cmd_valid  = 1'b1;
        cmd_opcode = opc;
        cmd_actag  = tag;
        cmd_pasid  = pasid;
    endtask

    task automatic idle();
        cmd_valid  = 1'b0;
        lkup_valid = 1'b0;
        tbl_clear  = 1'b0;
    endtask

    task automatic do_lookup(input logic [11:0] tag);
        lkup_valid = 1'b1;
        lkup_actag = tag;
        step();
        idle();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_rsp_valid", 32'(lkup_rsp_valid), 0);
        chk("rst_assign", 32'(assign_pulse), 0);
        chk("rst_err", 32'(err_range), 0);
        chk("rst_cnt", 32'(valid_cnt), 0);
        rst_n = 1'b1;
        step();

        // 1. basic assign and lookup
        drive_cmd(8'h50, 12'h105, 20'h0ABCD);
        step();
        idle();
        chk("t1_assign", 32'(assign_pulse), 1);
        chk("t1_reassign", 32'(reassign_pulse), 0);
        chk("t1_cnt", 32'(valid_cnt), 1);
        step();
        chk("t1_assign_drop", 32'(assign_pulse), 0);
        lkup_valid = 1'b1;
        lkup_actag = 12'h105;
        step();
        chk("t1_rsp_valid", 32'(lkup_rsp_valid), 1);
        chk("t1_hit", 32'(lkup_rsp_hit), 1);
        chk("t1_pasid", 32'(lkup_rsp_pasid), 32'h0ABCD);
        lkup_actag = 12'h106;
        step();
        idle();
        chk("t1_miss_valid", 32'(lkup_rsp_valid), 1);
        chk("t1_miss_hit", 32'(lkup_rsp_hit), 0);
        chk("t1_miss_pasid", 32'(lkup_rsp_pasid), 0);
        step();
        chk("t1_rsp_one_cycle", 32'(lkup_rsp_valid), 0);

        // 2. range errors, starting from an empty table
        tbl_clear = 1'b1;
        step();
        idle();
        chk("t2_cleared", 32'(valid_cnt), 0);
        drive_cmd(8'h50, 12'h110, 20'h00011);
        step();
        idle();
        chk("t2_err_hi", 32'(err_range), 1);
        chk("t2_no_assign_hi", 32'(assign_pulse), 0);
        drive_cmd(8'h50, 12'h0FF, 20'h00022);
        step();
        idle();
        chk("t2_no_assign_wrap", 32'(assign_pulse), 0);
        chk("t2_cnt", 32'(valid_cnt), 0);
        step();
        chk("t2_err_sticky", 32'(err_range), 1);
        // length above depth is clipped to 16
        cfg_actag_len = 12'd20;
        drive_cmd(8'h50, 12'h110, 20'h00033);
        step();
        idle();
        chk("t2_len_clip_assign", 32'(assign_pulse), 0);
        chk("t2_len_clip_cnt", 32'(valid_cnt), 0);
        do_lookup(12'h110);
        chk("t2_len_clip_lkup", 32'(lkup_rsp_hit), 0);
        cfg_actag_len = 12'd16;

        // 3. reassignment
        drive_cmd(8'h50, 12'h101, 20'h00001);
        step();
        chk("t3_a1_assign", 32'(assign_pulse), 1);
        chk("t3_a1_reassign", 32'(reassign_pulse), 0);
        drive_cmd(8'h50, 12'h101, 20'h00002);
        step();
        chk("t3_a2_assign", 32'(assign_pulse), 1);
        chk("t3_a2_reassign", 32'(reassign_pulse), 1);
        chk("t3_a2_cnt", 32'(valid_cnt), 1);
        drive_cmd(8'h50, 12'h101, 20'h00002);
        step();
        idle();
        chk("t3_a3_assign", 32'(assign_pulse), 1);
        chk("t3_a3_reassign", 32'(reassign_pulse), 0);
        chk("t3_a3_cnt", 32'(valid_cnt), 1);
        do_lookup(12'h101);
        chk("t3_lkup_hit", 32'(lkup_rsp_hit), 1);
        chk("t3_lkup_pasid", 32'(lkup_rsp_pasid), 32'h00002);

        // 4. same-cycle bypass, then a non-assign opcode
        drive_cmd(8'h50, 12'h103, 20'h12345);
        do_lookup(12'h103);
        chk("t4_bypass_hit", 32'(lkup_rsp_hit), 1);
        chk("t4_bypass_pasid", 32'(lkup_rsp_pasid), 32'h12345);
        chk("t4_cnt", 32'(valid_cnt), 2);
        drive_cmd(8'h20, 12'h104, 20'h0BEEF);
        step();
        idle();
        chk("t4_other_opc_assign", 32'(assign_pulse), 0);
        chk("t4_other_opc_cnt", 32'(valid_cnt), 2);
        do_lookup(12'h104);
        chk("t4_other_opc_lkup", 32'(lkup_rsp_hit), 0);

        // 5. fill the table, then clear with a same-cycle assign and lookup
        for (int i = 0; i < 16; i++) begin
            drive_cmd(8'h50, 12'h100 + 12'(i), 20'h00100 + 20'(i));
            step();
        end
        idle();
        chk("t5_full_cnt", 32'(valid_cnt), 16);
        do_lookup(12'h10F);
        chk("t5_last_pasid", 32'(lkup_rsp_pasid), 32'h0010F);
        tbl_clear  = 1'b1;
        drive_cmd(8'h50, 12'h102, 20'h0AAAA);
        do_lookup(12'h102);
        chk("t5_clr_cnt", 32'(valid_cnt), 0);
        chk("t5_clr_assign", 32'(assign_pulse), 0);
        chk("t5_clr_reassign", 32'(reassign_pulse), 0);
        chk("t5_clr_same_hit", 32'(lkup_rsp_hit), 0);
        do_lookup(12'h102);
        chk("t5_after_hit", 32'(lkup_rsp_hit), 0);
        chk("t5_after_pasid", 32'(lkup_rsp_pasid), 0);

        // 6. reset asserted in the same cycle as a lookup of a valid entry
        drive_cmd(8'h50, 12'h105, 20'h05555);
        step();
        idle();
        lkup_valid = 1'b1;
        lkup_actag = 12'h105;
        rst_n      = 1'b0;
        step();
        chk("t6_rsp_valid", 32'(lkup_rsp_valid), 0);
        chk("t6_hit", 32'(lkup_rsp_hit), 0);
        chk("t6_err", 32'(err_range), 0);
        chk("t6_cnt", 32'(valid_cnt), 0);
        chk("t6_assign", 32'(assign_pulse), 0);
        idle();
        rst_n = 1'b1;
        step();
        chk("t6_post_rsp_valid", 32'(lkup_rsp_valid), 0);
        do_lookup(12'h105);
        chk("t6_post_lkup_hit", 32'(lkup_rsp_hit), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
